// File: rtl/bnn_result_uart_tx.sv
// ---------------------------------------------------------------------------
// bnn_result_uart_tx
//
// Result transmitter for the microgreen BNN classifier. Takes one result
// (class index + score) over a valid/ready handshake, frames it as the
// 4-byte packet {HEADER, {6'b0,class}, score, xor-checksum} and shifts it
// out as 8N1 UART, LSB first, bytes back-to-back.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; gates acceptance of new results only
//   res_valid  BNN core has a result
//   res_class  predicted class index (2 bits)
//   res_score  popcount/confidence score (8 bits)
//   res_ready  block accepts a result this cycle (IDLE and enabled)
//   tx         UART serial out, idles high, registered
//   busy       packet in flight, registered
// ---------------------------------------------------------------------------
module bnn_result_uart_tx #(
   parameter int         CLKS_PER_BIT = 87,
   parameter logic [7:0] HEADER       = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       res_valid,
   input  logic [1:0] res_class,
   input  logic [7:0] res_score,
   output logic       res_ready,
   output logic       tx,
   output logic       busy
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] baud_q,     baud_d;
   logic [2:0]       bit_idx_q,  bit_idx_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       shift_q,    shift_d;
   logic [1:0]       class_q,    class_d;
   logic [7:0]       score_q,    score_d;
   logic             tx_q,       tx_d;
   logic             busy_q,     busy_d;

   logic             accept;
   logic             baud_done;
   logic [2:0]       bit_idx_inc;
   logic [1:0]       byte_idx_inc;

   // Byte 'idx' of the packet built from the captured result.
   function automatic logic [7:0] packet_byte(input logic [1:0] idx,
                                              input logic [1:0] cls,
                                              input logic [7:0] scr);
      logic [7:0] b1;
      b1 = {6'b0, cls};
      case (idx)
         2'd0:    return HEADER;
         2'd1:    return b1;
         2'd2:    return scr;
         default: return HEADER ^ b1 ^ scr;
      endcase
   endfunction

   // rst_n is folded in so res_ready stays low while reset is held, even
   // though the FSM already sits in IDLE.
   assign res_ready    = rst_n & ena & (state_q == ST_IDLE);
   assign accept       = res_valid & res_ready;
   assign baud_done    = (baud_q == BAUD_LAST);
   assign bit_idx_inc  = bit_idx_q + 3'd1;
   assign byte_idx_inc = byte_idx_q + 2'd1;

   assign tx   = tx_q;
   assign busy = busy_q;

   // Next-state logic. tx_d/busy_d are decided together with the state
   // transition so both outputs change on the same edge as the state.
   always_comb begin
      // NOTE: every _d starts as a hold of its _q so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      class_d    = class_q;
      score_d    = score_q;
      tx_d       = tx_q;
      busy_d     = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (accept) begin
               class_d    = res_class;
               score_d    = res_score;
               byte_idx_d = 2'd0;
               shift_d    = HEADER;
               state_d    = ST_START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end

         ST_START: begin
            if (baud_done) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
               state_d   = ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (baud_done) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_inc;
                  tx_d      = shift_q[bit_idx_inc];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (baud_done) begin
               baud_d = '0;
               if (byte_idx_q == 2'd3) begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  // Next byte starts immediately: no idle bits between bytes.
                  byte_idx_d = byte_idx_inc;
                  shift_d    = packet_byte(byte_idx_inc, class_q, score_q);
                  tx_d       = 1'b0;
                  state_d    = ST_START;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            baud_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Asynchronous reset drops any packet in flight: the line returns high
   // and busy clears without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 2'd0;
         shift_q    <= 8'h00;
         class_q    <= 2'd0;
         score_q    <= 8'h00;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge value of its _d, independent of statement order.
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         class_q    <= class_d;
         score_q    <= score_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

endmodule
